// File: rtl/companion_step_sched_pkg.sv
// ---------------------------------------------------------------------------
// companion_step_sched_pkg
// Shared definitions for the LC companion-model step scheduler:
//   - Q-format constants (signed Q8.8 at defaults, saturation limits)
//   - FSM state encoding for the scheduler
//   - saturating add / subtract / negate helpers (computed one bit wider,
//     then clamped back to Q_W bits)
// ---------------------------------------------------------------------------
package companion_step_sched_pkg;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 8;

  localparam logic [Q_W-1:0] QMAX = {1'b0, {(Q_W-1){1'b1}}};
  localparam logic [Q_W-1:0] QMIN = {1'b1, {(Q_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MUL_L = 3'd2,
    S_MUL_C = 3'd3,
    S_UPD   = 3'd4,
    S_ZOUT  = 3'd5
  } state_t;

  // Clamp a Q_W+1 bit signed intermediate back into Q_W bits.
  function automatic logic [Q_W-1:0] sat_wide(input logic [Q_W:0] s);
    if (s[Q_W] != s[Q_W-1]) begin
      return s[Q_W] ? QMIN : QMAX;
    end
    return s[Q_W-1:0];
  endfunction

  function automatic logic [Q_W-1:0] sat_add(input logic [Q_W-1:0] a,
                                             input logic [Q_W-1:0] b);
    return sat_wide({a[Q_W-1], a} + {b[Q_W-1], b});
  endfunction

  function automatic logic [Q_W-1:0] sat_sub(input logic [Q_W-1:0] a,
                                             input logic [Q_W-1:0] b);
    return sat_wide({a[Q_W-1], a} - {b[Q_W-1], b});
  endfunction

  // Negating the most negative value clamps to QMAX.
  function automatic logic [Q_W-1:0] sat_neg(input logic [Q_W-1:0] a);
    return sat_sub({Q_W{1'b0}}, a);
  endfunction

endpackage

// File: rtl/companion_step_sched_mul.sv
// ---------------------------------------------------------------------------
// fxp_mul_sat
// Registered signed fixed-point multiplier, latency 1.
//   clk, rst_n : clock, synchronous active-low reset
//   a, b       : signed operands (W bits, FRAC fractional bits)
//   p          : registered product, truncated toward -inf and saturated
// ---------------------------------------------------------------------------
module fxp_mul_sat
  import companion_step_sched_pkg::*;
#(
  parameter int W    = Q_W,
  parameter int FRAC = Q_FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic        [W-1:0] p
);

  logic signed [2*W-1:0] prod;
  logic        [W-1:0]   result;

  // Full-width product, then keep the Q-aligned window. Dropping the low
  // FRAC bits of a two's complement value floors toward -inf. If the bits
  // above the window are not a copy of its sign bit the value overflowed.
  always_comb begin
    prod   = a * b;
    result = prod[W+FRAC-1:FRAC];
    if (prod[2*W-1:W+FRAC-1] != {(W-FRAC+1){prod[2*W-1]}}) begin
      result = prod[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // Output register gives the single cycle of latency the scheduler expects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      p <= result;
    end
  end

endmodule

// File: rtl/companion_step_sched.sv
// ---------------------------------------------------------------------------
// companion_step_sched
// Per-timestep scheduler for the LC companion-model update. One shared
// multiplier is time-multiplexed for
//   I_L <= I_L + (v1-v2)*GL        I_C <= -I_C + v2*GC
// and the source vector z = [-I_L, I_L+I_C, E] is then formed.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start, clr_state    : step request / history clear (IDLE only)
//   v1, v2, e_in        : node voltages and source value (signed Q8.8)
//   gl_coef, gc_coef    : T/L and 4C/T coefficients (signed Q8.8)
//   busy, done          : FSM not idle / one-cycle result-valid pulse
//   i_l, i_c            : history currents
//   z0, z1, z2          : source vector
//   step_count          : completed steps, wraps
// ---------------------------------------------------------------------------
module companion_step_sched
  import companion_step_sched_pkg::*;
#(
  parameter int W    = Q_W,
  parameter int FRAC = Q_FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clr_state,
  input  logic [W-1:0] v1,
  input  logic [W-1:0] v2,
  input  logic [W-1:0] e_in,
  input  logic [W-1:0] gl_coef,
  input  logic [W-1:0] gc_coef,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] i_l,
  output logic [W-1:0] i_c,
  output logic [W-1:0] z0,
  output logic [W-1:0] z1,
  output logic [W-1:0] z2,
  output logic [15:0]  step_count
);

  state_t state, state_next;

  logic [W-1:0] v1_q, v2_q, e_q, gl_q, gc_q;
  logic [W-1:0] diff, prod_l;
  logic [W-1:0] mul_a, mul_b, mul_p;
  logic         accept, clear;

  fxp_mul_sat #(.W(W), .FRAC(FRAC)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p)
  );

  assign busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and multiplier operand selection. Clear has priority over
  // start in IDLE; both are ignored in every other state. The multiplier
  // sees diff*gl in MUL_L and v2*gc in MUL_C.
  always_comb begin
    state_next = state;
    mul_a      = diff;
    mul_b      = gl_q;
    accept     = 1'b0;
    clear      = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_state) begin
          clear = 1'b1;
        end else if (start) begin
          accept     = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD:  state_next = S_MUL_L;
      S_MUL_L: state_next = S_MUL_C;
      S_MUL_C: begin
        mul_a      = v2_q;
        mul_b      = gc_q;
        state_next = S_UPD;
      end
      S_UPD:   state_next = S_ZOUT;
      S_ZOUT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath. In UPD the multiplier output holds prod_C; both history
  // updates read the pre-update i_l/i_c. The z vector reads the freshly
  // updated history one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q       <= '0;
      v2_q       <= '0;
      e_q        <= '0;
      gl_q       <= '0;
      gc_q       <= '0;
      diff       <= '0;
      prod_l     <= '0;
      i_l        <= '0;
      i_c        <= '0;
      z0         <= '0;
      z1         <= '0;
      z2         <= '0;
      done       <= 1'b0;
      step_count <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        v1_q <= v1;
        v2_q <= v2;
        e_q  <= e_in;
        gl_q <= gl_coef;
        gc_q <= gc_coef;
      end
      if (clear) begin
        i_l        <= '0;
        i_c        <= '0;
        step_count <= '0;
      end
      case (state)
        S_LOAD:  diff <= sat_sub(v1_q, v2_q);
        S_MUL_C: prod_l <= mul_p;
        S_UPD: begin
          i_l <= sat_add(i_l, prod_l);
          i_c <= sat_sub(mul_p, i_c);
        end
        S_ZOUT: begin
          z0         <= sat_neg(i_l);
          z1         <= sat_add(i_l, i_c);
          z2         <= e_q;
          done       <= 1'b1;
          step_count <= step_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_companion_step_sched.sv
// ---------------------------------------------------------------------------
// tb_companion_step_sched
// Self-checking bench for companion_step_sched: a table of step vectors with
// hand-derived expected results feeds a scoreboard queue, followed by
// hand-written sequences for mid-step start/clear/reset and clear-in-IDLE.
// ---------------------------------------------------------------------------
module tb_companion_step_sched;

  typedef struct {
    logic        do_reset;
    logic [15:0] v1, v2, gl, gc, e;
    logic [15:0] exp_il, exp_ic, exp_z0, exp_z1, exp_z2, exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clr_state = 1'b0;
  logic [15:0] v1 = '0, v2 = '0, e_in = '0, gl_coef = '0, gc_coef = '0;
  logic        busy, done;
  logic [15:0] i_l, i_c, z0, z1, z2, step_count;

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  vec_t vecs[7];
  vec_t sb[$];

  companion_step_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clr_state  (clr_state),
    .v1         (v1),
    .v2         (v2),
    .e_in       (e_in),
    .gl_coef    (gl_coef),
    .gc_coef    (gc_coef),
    .busy       (busy),
    .done       (done),
    .i_l        (i_l),
    .i_c        (i_c),
    .z0         (z0),
    .z1         (z1),
    .z2         (z2),
    .step_count (step_count)
  );

  // Free-running clock and a rising-edge counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end else begin
      passed++;
    end
  endtask

  // Hold reset for two edges; returns on a falling edge with reset released.
  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    start     = 1'b0;
    clr_state = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on a falling edge: drive one step request, optionally queue its
  // expected result, and return on the falling edge after the accept edge.
  task automatic applyStimulus(input vec_t v, input bit push);
    v1      = v.v1;
    v2      = v.v2;
    gl_coef = v.gl;
    gc_coef = v.gc;
    e_in    = v.e;
    start   = 1'b1;
    if (push) sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    accept_cyc = cyc;
    checkOutput("busy_after_accept", {15'd0, busy}, 16'd1);
    checkOutput("done_low_after_accept", {15'd0, done}, 16'd0);
  endtask

  // Bounded wait for done; returns on the falling edge where done is seen.
  task automatic waitDone(output int lat);
    while (!done && (cyc - accept_cyc) < 20) @(negedge clk);
    lat = cyc - accept_cyc + 1;
    checkOutput("done_seen", {15'd0, done}, 16'd1);
  endtask

  task automatic compareStep();
    vec_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_nonempty", 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("i_l", i_l, e.exp_il);
      checkOutput("i_c", i_c, e.exp_ic);
      checkOutput("z0", z0, e.exp_z0);
      checkOutput("z1", z1, e.exp_z1);
      checkOutput("z2", z2, e.exp_z2);
      checkOutput("step_count", step_count, e.exp_cnt);
    end
  endtask

  task automatic countDone(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int lat;
    int extra;

    //            rst   v1       v2       gl       gc       e        i_l      i_c      z0       z1       z2       cnt
    vecs[0] = '{1'b1, 16'h0200, 16'h0080, 16'h0040, 16'h0100, 16'h0700, 16'h0060, 16'h0080, 16'hFFA0, 16'h00E0, 16'h0700, 16'd1};
    vecs[1] = '{1'b0, 16'h0200, 16'h0080, 16'h0040, 16'h0100, 16'h0700, 16'h00C0, 16'h0000, 16'hFF40, 16'h00C0, 16'h0700, 16'd2};
    vecs[2] = '{1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h8001, 16'h7FFF, 16'h0000, 16'd1};
    vecs[3] = '{1'b0, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h8001, 16'h7FFF, 16'h0000, 16'd2};
    vecs[4] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0080, 16'h0000, 16'h0123, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0123, 16'd1};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 16'hFF00, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, 16'hFF00, 16'd1};
    vecs[6] = '{1'b0, 16'h0000, 16'h0100, 16'h0100, 16'hFF00, 16'h0000, 16'hFEFF, 16'hFF00, 16'h0101, 16'hFDFF, 16'h0000, 16'd2};

    doReset();
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_done", {15'd0, done}, 16'd0);
    checkOutput("reset_i_l", i_l, 16'h0000);
    checkOutput("reset_i_c", i_c, 16'h0000);
    checkOutput("reset_z0", z0, 16'h0000);
    checkOutput("reset_z1", z1, 16'h0000);
    checkOutput("reset_z2", z2, 16'h0000);
    checkOutput("reset_step_count", step_count, 16'h0000);

    // Table vectors; rows without reset start on the done cycle of the
    // previous row, so start is high in the done cycle (back-to-back).
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_reset) doReset();
      applyStimulus(vecs[i], 1'b1);
      waitDone(lat);
      checkOutput("latency", lat[15:0], 16'd6);
      compareStep();
    end
    @(negedge clk);
    checkOutput("done_one_cycle", {15'd0, done}, 16'd0);
    checkOutput("idle_after_step", {15'd0, busy}, 16'd0);

    // start/clr_state pulsed while busy, with inputs scrambled after accept.
    doReset();
    applyStimulus(vecs[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      v1        = 16'($urandom);
      v2        = 16'($urandom);
      gl_coef   = 16'($urandom);
      gc_coef   = 16'($urandom);
      e_in      = 16'($urandom);
      start     = 1'b1;
      clr_state = (i == 1);
      @(negedge clk);
    end
    start     = 1'b0;
    clr_state = 1'b0;
    waitDone(lat);
    compareStep();
    countDone(8, extra);
    checkOutput("busy_no_extra_done", extra[15:0], 16'd0);
    checkOutput("busy_no_extra_step", step_count, 16'd1);

    // Reset asserted so that it is sampled at edge k+3.
    applyStimulus(vecs[1], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    countDone(10, extra);
    checkOutput("abort_no_done", extra[15:0], 16'd0);
    checkOutput("abort_busy", {15'd0, busy}, 16'd0);
    checkOutput("abort_i_l", i_l, 16'h0000);
    checkOutput("abort_i_c", i_c, 16'h0000);
    checkOutput("abort_z0", z0, 16'h0000);
    checkOutput("abort_z1", z1, 16'h0000);
    checkOutput("abort_step_count", step_count, 16'h0000);

    // Two steps, then clr_state and start together in IDLE.
    doReset();
    applyStimulus(vecs[0], 1'b1);
    waitDone(lat);
    compareStep();
    applyStimulus(vecs[1], 1'b1);
    waitDone(lat);
    compareStep();
    @(negedge clk);
    v1        = 16'h1234;
    start     = 1'b1;
    clr_state = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    clr_state = 1'b0;
    checkOutput("clr_busy", {15'd0, busy}, 16'd0);
    checkOutput("clr_i_l", i_l, 16'h0000);
    checkOutput("clr_i_c", i_c, 16'h0000);
    checkOutput("clr_step_count", step_count, 16'h0000);
    checkOutput("clr_z0_kept", z0, 16'hFF40);
    checkOutput("clr_z1_kept", z1, 16'h00C0);
    checkOutput("clr_z2_kept", z2, 16'h0700);
    countDone(8, extra);
    checkOutput("clr_no_done", extra[15:0], 16'd0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
